// File: rtl/dsp_bb_pkg.sv
// Shared helpers for the DSP building blocks: log2 sizing, adder output
// width and tag width derivation, and the result buffer depth.
package dsp_bb_pkg;

  localparam int FIFO_DEPTH = 2;

  // Ceiling log2, evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A signed sum of two operands needs one bit beyond the wider operand.
  function automatic int calc_outwid(input int aw, input int bw);
    return ((aw > bw) ? aw : bw) + 1;
  endfunction

  // Requester tag width; never narrower than one bit.
  function automatic int calc_idw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/signed_adder.sv
// Registered signed adder with full bit growth. The output register has
// no enable and no reset: a result appears one clock after its operands.
module signed_adder
  import dsp_bb_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 16,
  localparam int OUTWID = calc_outwid(AWIDTH, BWIDTH)
) (
  input  logic                     i_clk,
  input  logic [AWIDTH-1:0]        i_a,
  input  logic [BWIDTH-1:0]        i_b,
  output logic signed [OUTWID-1:0] o_sum
);

  logic signed [OUTWID-1:0] w_a_ext;
  logic signed [OUTWID-1:0] w_b_ext;

  assign w_a_ext = {{(OUTWID-AWIDTH){i_a[AWIDTH-1]}}, i_a};
  assign w_b_ext = {{(OUTWID-BWIDTH){i_b[BWIDTH-1]}}, i_b};

  // Register the sign-extended sum every clock.
  always_ff @(posedge i_clk) begin
    o_sum <= w_a_ext + w_b_ext;
  end

endmodule

// File: rtl/signed_adder_arbiter.sv
// Round-robin front end sharing one registered signed_adder among NREQ
// requesters; results return tagged, in grant order, via a 2-entry buffer.
// Optional build macro SIGNED_ADDER_ARB_STATS_EN adds grant/stall counters.
module signed_adder_arbiter
  import dsp_bb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 16,
  localparam int OUTWID = calc_outwid(AWIDTH, BWIDTH),
  localparam int IDW    = calc_idw(NREQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ*AWIDTH-1:0]   i_req_a,
  input  logic [NREQ*BWIDTH-1:0]   i_req_b,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic signed [OUTWID-1:0] o_res_sum,
  output logic [IDW-1:0]           o_res_id,
  output logic                     o_busy
`ifdef SIGNED_ADDER_ARB_STATS_EN
  ,
  output logic [31:0]              o_issue_cnt,
  output logic [31:0]              o_stall_cnt
`endif
);

  logic [IDW-1:0]           r_ptr;
  logic                     r_s1_v;
  logic [IDW-1:0]           r_s1_id;
  logic [1:0]               r_cnt;
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic signed [OUTWID-1:0] r_fifo_sum [FIFO_DEPTH];
  logic [IDW-1:0]           r_fifo_id  [FIFO_DEPTH];

  logic                     w_pop;
  logic [2:0]               w_occ;
  logic                     w_issue_ok;
  logic                     w_grant_found;
  logic [IDW-1:0]           w_grant_idx;
  logic [IDW-1:0]           w_cand;
  int                       w_idx;
  logic                     w_issue;
  logic [AWIDTH-1:0]        w_mux_a;
  logic [BWIDTH-1:0]        w_mux_b;
  logic signed [OUTWID-1:0] w_add_sum;

  // The adder register cannot stall, so only issue when the op already in
  // the adder plus the buffer contents will still leave room next edge.
  assign o_res_valid = (r_cnt != 2'd0);
  assign w_pop       = o_res_valid & i_res_ready;
  assign w_occ       = 3'(r_cnt) + 3'(r_s1_v) - 3'(w_pop);
  assign w_issue_ok  = (w_occ <= 3'd1);

  // Round-robin search from the requester after the last grant, wrapping.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_idx         = 0;
    w_cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      w_cand = IDW'(w_idx);
      if (!w_grant_found && i_req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // No grants are handed out while reset is held.
  assign w_issue     = w_grant_found & w_issue_ok & i_rst_n;
  assign o_req_ready = w_issue ? (NREQ'(1) << w_grant_idx) : '0;
  assign w_mux_a     = i_req_a[w_grant_idx*AWIDTH +: AWIDTH];
  assign w_mux_b     = i_req_b[w_grant_idx*BWIDTH +: BWIDTH];

  signed_adder #(
    .AWIDTH(AWIDTH),
    .BWIDTH(BWIDTH)
  ) u_adder (
    .i_clk(i_clk),
    .i_a  (w_mux_a),
    .i_b  (w_mux_b),
    .o_sum(w_add_sum)
  );

  // Pointer, stage-1 tracking and the result buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr    <= IDW'(NREQ-1);
      r_s1_v   <= 1'b0;
      r_s1_id  <= '0;
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_sum[i] <= '0;
        r_fifo_id[i]  <= '0;
      end
    end else begin
      if (w_issue) begin
        r_ptr <= w_grant_idx;
      end
      r_s1_v  <= w_issue;
      r_s1_id <= w_grant_idx;
      if (r_s1_v) begin
        r_fifo_sum[r_wr_ptr] <= w_add_sum;
        r_fifo_id[r_wr_ptr]  <= r_s1_id;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= w_occ[1:0];
    end
  end

  assign o_res_sum = r_fifo_sum[r_rd_ptr];
  assign o_res_id  = r_fifo_id[r_rd_ptr];
  assign o_busy    = r_s1_v | (r_cnt != 2'd0);

`ifdef SIGNED_ADDER_ARB_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  // Count grants and cycles where someone waited without being granted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if ((|i_req_valid) && !w_issue) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_issue_cnt = r_issue_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_signed_adder_arbiter.sv
// Bench for signed_adder_arbiter: table of single-requester vectors, then
// back-pressure, reset-while-full and full-load round-robin sequences.
// A scoreboard queue holds expected {sum,id} per observed grant.
module tb_signed_adder_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int BW   = 16;
  localparam int OW   = 17;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [NREQ-1:0]      i_req_valid = '0;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*AW-1:0]   i_req_a = '0;
  logic [NREQ*BW-1:0]   i_req_b = '0;
  logic                 o_res_valid;
  logic                 i_res_ready = 1'b1;
  logic signed [OW-1:0] o_res_sum;
  logic [IDW-1:0]       o_res_id;
  logic                 o_busy;
`ifdef SIGNED_ADDER_ARB_STATS_EN
  logic [31:0]          o_issue_cnt;
  logic [31:0]          o_stall_cnt;
`endif

  always #5 clk = ~clk;

  signed_adder_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_a    (i_req_a),
    .i_req_b    (i_req_b),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_sum  (o_res_sum),
    .o_res_id   (o_res_id),
    .o_busy     (o_busy)
`ifdef SIGNED_ADDER_ARB_STATS_EN
    ,
    .o_issue_cnt(o_issue_cnt),
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  typedef struct {
    int     id;
    longint sum;
  } exp_t;

  typedef struct {
    int     id;
    int     a;
    int     b;
    longint exp_sum;
  } vec_t;

  exp_t   sb[$];
  int     grant_log[$];
  int     n_pops = 0;
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: grants push expectations, output transfers pop and compare.
  exp_t   m_e;
  exp_t   m_got;
  longint m_sa;
  longint m_sb;
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_req_ready != '0) begin
        chk("grant_onehot", $countones(o_req_ready), 1);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (i_req_valid[k] && o_req_ready[k]) begin
          m_sa = longint'($signed(i_req_a[k*AW +: AW]));
          m_sb = longint'($signed(i_req_b[k*BW +: BW]));
          m_e.id  = k;
          m_e.sum = m_sa + m_sb;
          sb.push_back(m_e);
          grant_log.push_back(k);
        end
      end
      if (o_res_valid && i_res_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          m_got = sb.pop_front();
          chk("sb_sum", longint'(o_res_sum), m_got.sum);
          chk("sb_id", longint'(o_res_id), longint'(m_got.id));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    i_req_a[k*AW +: AW] = AW'(a);
    i_req_b[k*BW +: BW] = BW'(b);
  endtask

  task automatic set_all();
    for (int k = 0; k < NREQ; k++) begin
      set_op(k, 1000 * (k + 1) - 7, -(k * 313) - 1);
    end
    i_req_valid = '1;
  endtask

  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    step();
    chk({tag, "_res_valid"}, longint'(o_res_valid), 0);
    chk({tag, "_busy"}, longint'(o_busy), 0);
    chk({tag, "_res_sum"}, longint'(o_res_sum), 0);
    chk({tag, "_res_id"}, longint'(o_res_id), 0);
    chk({tag, "_req_ready"}, longint'(o_req_ready), 0);
    sb.delete();
    grant_log.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((o_busy || sb.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_drained_busy"}, longint'(o_busy), 0);
    chk({tag, "_drained_sb"}, longint'(sb.size()), 0);
  endtask

  vec_t tbl[6];
  int   n;
  int   lat;
  int   g0;
  int   p0;

  initial begin
    tbl[0] = '{id: 1, a: 10,     b: -15,    exp_sum: -5};
    tbl[1] = '{id: 0, a: -32768, b: -32768, exp_sum: -65536};
    tbl[2] = '{id: 3, a: 32767,  b: 32767,  exp_sum: 65534};
    tbl[3] = '{id: 2, a: 32767,  b: -32768, exp_sum: -1};
    tbl[4] = '{id: 1, a: -1,     b: 1,      exp_sum: 0};
    tbl[5] = '{id: 2, a: -20000, b: -20000, exp_sum: -40000};

    step();
    do_reset("reset");
    i_rst_n = 1'b1;
    step();

    // Single-requester vectors: grant, 2-cycle latency, sum and tag.
    for (int v = 0; v < 6; v++) begin
      i_res_ready = 1'b1;
      set_op(tbl[v].id, tbl[v].a, tbl[v].b);
      i_req_valid[tbl[v].id] = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_req_ready[tbl[v].id] && n < 20);
      chk($sformatf("tbl%0d_grant", v), longint'(o_req_ready[tbl[v].id]), 1);
      step();
      i_req_valid = '0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!o_res_valid && lat < 10);
      chk($sformatf("tbl%0d_latency", v), lat, 2);
      chk($sformatf("tbl%0d_sum", v), longint'(o_res_sum), tbl[v].exp_sum);
      chk($sformatf("tbl%0d_id", v), longint'(o_res_id), longint'(tbl[v].id));
      step();
    end
    drain("tbl");

    // Back-pressure: exactly two ops accepted, then grants stop.
    i_res_ready = 1'b0;
    g0 = grant_log.size();
    set_all();
    repeat (8) @(negedge clk);
    #1;
    chk("bp_grants", grant_log.size() - g0, 2);
    chk("bp_res_valid", longint'(o_res_valid), 1);
    chk("bp_busy", longint'(o_busy), 1);
    chk("bp_req_ready", longint'(o_req_ready), 0);
    step();
    i_req_valid = '0;
    p0 = n_pops;
    i_res_ready = 1'b1;
    drain("bp");
    chk("bp_pops", n_pops - p0, 2);

    // Reset while two results sit in the buffer.
    i_res_ready = 1'b0;
    set_all();
    repeat (6) step();
    chk("rstfull_res_valid_before", longint'(o_res_valid), 1);
    do_reset("rstfull");

    // Full load: strict rotation 0,1,2,3,... and one result per cycle.
    i_res_ready = 1'b1;
    i_rst_n = 1'b1;
    p0 = n_pops;
    repeat (12) @(negedge clk);
    #1;
    chk("rr_grant_count", grant_log.size(), 12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), grant_log[i], i % NREQ);
    end
    chk("rr_results", n_pops - p0, 10);
    step();
    i_req_valid = '0;
    drain("rr");

`ifdef SIGNED_ADDER_ARB_STATS_EN
    // Statistics: 8 free-flowing grants, then 2 grants plus 5 stalls.
    do_reset("stats_reset");
    chk("stats_issue_reset", longint'(o_issue_cnt), 0);
    chk("stats_stall_reset", longint'(o_stall_cnt), 0);
    i_rst_n = 1'b1;
    step();
    i_res_ready = 1'b1;
    set_op(0, 5, 6);
    i_req_valid = 4'b0001;
    repeat (8) @(posedge clk);
    #1;
    i_req_valid = '0;
    repeat (5) step();
    i_res_ready = 1'b0;
    i_req_valid = 4'b0001;
    repeat (7) step();
    i_req_valid = '0;
    step();
    chk("stats_issue_cnt", longint'(o_issue_cnt), 10);
    chk("stats_stall_cnt", longint'(o_stall_cnt), 5);
    i_res_ready = 1'b1;
    drain("stats");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
